// File: rtl/ef_gpio8_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ef_gpio8_seq_pkg
//  Description : Shared constants for the EF_GPIO8 pattern sequencer:
//                GPIO8 register offsets, AHB-Lite HTRANS/HSIZE encodings
//                and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ef_gpio8_seq_pkg;

    // GPIO8 slave register offsets (added to the slave base address)
    localparam logic [15:0] REG_DATAI = 16'h0000;
    localparam logic [15:0] REG_DATAO = 16'h0004;
    localparam logic [15:0] REG_DIR   = 16'h0008;

    // AHB-Lite encodings
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;

    // Sequencer state encoding
    typedef logic [3:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 4'd0;
    localparam seq_state_t ST_DIR_A = 4'd1;
    localparam seq_state_t ST_DIR_D = 4'd2;
    localparam seq_state_t ST_DAT_A = 4'd3;
    localparam seq_state_t ST_DAT_D = 4'd4;
    localparam seq_state_t ST_WAIT  = 4'd5;
    localparam seq_state_t ST_FIN   = 4'd6;
    localparam seq_state_t ST_RB_A  = 4'd7;
    localparam seq_state_t ST_RB_D  = 4'd8;

endpackage
`default_nettype wire

// File: rtl/ef_gpio8_seq_patmem.sv
`default_nettype none
// ============================================================================
//  Module      : ef_gpio8_seq_patmem
//  Description : DEPTH x 8 register-file pattern memory, one synchronous
//                write port and one asynchronous read port. Not reset.
//  Ports       : clk      - clock
//                i_we     - write strobe
//                i_waddr  - write index
//                i_wdata  - write data
//                i_raddr  - read index
//                o_rdata  - read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module ef_gpio8_seq_patmem
    import ef_gpio8_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [7:0]               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [7:0]               o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ef_gpio8_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ef_gpio8_pattern_seq
//  Description : AHB-Lite master that plays an 8-bit pattern on an EF_GPIO8
//                slave: one DIR write, then successive DATAO writes spaced
//                by a programmable step interval. One-shot or looping.
//  Optional    : EF_GPIO8_SEQ_READBACK_EN - after every DATAO write, read
//                DATAI back and flag (sticky 'mismatch') any difference on
//                the bits configured as outputs by dir_val.
//  Ports       : HCLK/HRESETn         - clock, async active-low reset
//                start/stop           - sequence control pulses
//                loop_en              - wrap to entry 0 after pat_len
//                dir_val              - DIR value written at start
//                pat_len              - index of last entry played
//                step_div             - idle cycles between writes - 1
//                pat_we/addr/wdata    - pattern memory write port
//                busy/done/err        - status
//                step_idx             - index of entry last written
//                H*                   - AHB-Lite master interface
//  Revision    : 1.0  initial release
// ============================================================================
module ef_gpio8_pattern_seq
    import ef_gpio8_seq_pkg::*;
#(
    parameter int             DEPTH = 16,
    parameter int             AW    = 16,
    parameter int             DIV_W = 16,
    parameter logic [AW-1:0]  BASE  = '0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [7:0]               dir_val,
    input  logic [$clog2(DEPTH)-1:0] pat_len,
    input  logic [DIV_W-1:0]         step_div,
    input  logic                     pat_we,
    input  logic [$clog2(DEPTH)-1:0] pat_addr,
    input  logic [7:0]               pat_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
`ifdef EF_GPIO8_SEQ_READBACK_EN
    output logic                     mismatch,
`endif
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic [AW-1:0]            HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [31:0]              HWDATA,
    input  logic [31:0]              HRDATA,
    input  logic                     HREADY,
    input  logic                     HRESP
);

    localparam int IW = $clog2(DEPTH);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_step_idx;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic [7:0]       r_dir;
    logic             r_err;
    logic             r_stop;
    logic [7:0]       w_pat_rdata;
    logic             w_err_now;
    logic             w_last;
    logic             w_end_hit;
    logic             w_enter_wait;

    ef_gpio8_seq_patmem #(
        .DEPTH (DEPTH)
    ) u_patmem (
        .clk     (HCLK),
        .i_we    (pat_we),
        .i_waddr (pat_addr),
        .i_wdata (pat_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_pat_rdata)
    );

    // An error seen earlier in the current data phase (first cycle of the
    // two-cycle ERROR response) is remembered in r_err, which start clears.
    assign w_err_now    = HRESP | r_err;
    assign w_last       = (r_idx >= pat_len);
    // Stop is honoured at the end of a completed write, together with the
    // natural end of a one-shot run.
    assign w_end_hit    = r_stop | stop | (w_last & ~loop_en);
    assign w_enter_wait = (w_state_nxt == ST_WAIT) && (r_state != ST_WAIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_DIR_A;
            ST_DIR_A: if (HREADY) w_state_nxt = ST_DIR_D;
            ST_DIR_D: if (HREADY) w_state_nxt = w_err_now ? ST_FIN : ST_DAT_A;
            ST_DAT_A: if (HREADY) w_state_nxt = ST_DAT_D;
            ST_DAT_D: begin
                if (HREADY) begin
                    if (w_err_now) begin
                        w_state_nxt = ST_FIN;
`ifdef EF_GPIO8_SEQ_READBACK_EN
                    end else begin
                        w_state_nxt = ST_RB_A;
`else
                    end else if (w_end_hit) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_WAIT;
`endif
                    end
                end
            end
            ST_RB_A:  if (HREADY) w_state_nxt = ST_RB_D;
            ST_RB_D: begin
                if (HREADY) begin
                    if (w_err_now || w_end_hit) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_DAT_A;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_step_idx <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_dir      <= '0;
            r_err      <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Stop requests are only captured while a run is in progress;
            // a stop coinciding with an accepted start is dropped.
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_err  <= 1'b0;
                    r_stop <= 1'b0;
                    r_idx  <= '0;
                    r_dir  <= dir_val;
                end
            end else if (r_state == ST_FIN) begin
                r_stop <= 1'b0;
            end else if (stop) begin
                r_stop <= 1'b1;
            end

            case (r_state)
                ST_DIR_D, ST_RB_D: begin
                    if (HRESP) r_err <= 1'b1;
                end
                ST_DAT_A: begin
                    // Entry value captured as the address phase completes,
                    // so pattern writes up to this point take effect.
                    if (HREADY) r_data <= w_pat_rdata;
                end
                ST_DAT_D: begin
                    if (HRESP) begin
                        r_err <= 1'b1;
                    end else if (HREADY && !r_err) begin
                        r_step_idx <= r_idx;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_idx <= w_last ? '0 : r_idx + IW'(1);
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: ;
            endcase

            if (w_enter_wait) begin
                r_cnt <= step_div;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional readback compare
    // ------------------------------------------------------------------
`ifdef EF_GPIO8_SEQ_READBACK_EN
    logic        r_mism;
    logic [23:0] w_unused_rdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mism <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_mism <= 1'b0;
        end else if (r_state == ST_RB_D && HREADY && !w_err_now &&
                     (((HRDATA[7:0] ^ r_data) & r_dir) != 8'h00)) begin
            // Only pins driven as outputs (DIR bit = 1) are compared.
            r_mism <= 1'b1;
        end
    end

    assign mismatch       = r_mism;
    assign w_unused_rdata = HRDATA[31:8];
`else
    logic [31:0] w_unused_rdata;
    assign w_unused_rdata = HRDATA;
`endif

    // ------------------------------------------------------------------
    // Outputs, decoded from the state register. Address/control only
    // change on state changes, so they hold through HREADY=0 stalls.
    // ------------------------------------------------------------------
    always_comb begin
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = '0;
        HWDATA = 32'h0000_0000;
        case (r_state)
            ST_DIR_A: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = BASE + AW'(REG_DIR);
            end
            ST_DIR_D: HWDATA = {24'h00_0000, r_dir};
            ST_DAT_A: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = BASE + AW'(REG_DATAO);
            end
            ST_DAT_D: HWDATA = {24'h00_0000, r_data};
            ST_RB_A: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = BASE + AW'(REG_DATAI);
            end
            default: ;
        endcase
    end

    assign HSIZE    = HSIZE_WORD;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done     = (r_state == ST_FIN);
    assign err      = r_err;
    assign step_idx = r_step_idx;

endmodule
`default_nettype wire
